// File: rtl/rt_frame_scheduler.sv
// Frame sequencer for the ray-tracing coprocessor: loads the configuration burst,
// issues raster-order pixel requests under a credit limit, and streams results out.
module rt_frame_scheduler #(
    parameter int CFG_WORDS  = 27,
    parameter int WIDTH      = 32,
    parameter int HEIGHT     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         aclk,
    input  logic                         areset,
    output logic                         s_axis_tready,
    input  logic [DATA_W-1:0]            s_axis_tdata,
    input  logic                         s_axis_tlast,
    input  logic                         s_axis_tvalid,
    output logic                         cfg_wr_en,
    output logic [$clog2(CFG_WORDS)-1:0] cfg_wr_addr,
    output logic [DATA_W-1:0]            cfg_wr_data,
    output logic                         req_valid,
    input  logic                         req_ready,
    output logic [$clog2(WIDTH)-1:0]     req_x,
    output logic [$clog2(HEIGHT)-1:0]    req_y,
    input  logic                         res_valid,
    input  logic [DATA_W-1:0]            res_data,
    output logic                         m_axis_tvalid,
    output logic [DATA_W-1:0]            m_axis_tdata,
    output logic                         m_axis_tlast,
    input  logic                         m_axis_tready,
    output logic                         busy,
    output logic                         cfg_err,
    output logic                         frame_done
);
    localparam int NPIX = WIDTH * HEIGHT;
    localparam int CAW  = $clog2(CFG_WORDS);
    localparam int XW   = $clog2(WIDTH);
    localparam int YW   = $clog2(HEIGHT);
    localparam int PW   = $clog2(NPIX + 1);
    localparam int OW   = $clog2(FIFO_DEPTH + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {LOAD, SKIP, RENDER} state_t;

    state_t          state_q, state_d;
    logic [CAW-1:0]  cfg_cnt_q, cfg_cnt_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [PW-1:0]   issue_cnt_q, issue_cnt_d;
    logic [PW-1:0]   out_cnt_q, out_cnt_d;
    logic [OW-1:0]   outst_q, outst_d;
    logic [OW-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            cfg_err_q, cfg_err_d;
    logic            frame_done_q, frame_done_d;
    logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];

    logic [OW:0] credit_sum;
    logic        req_hs, push, pop, last_hs;

    // Requests are throttled so every in-flight result already owns a FIFO slot.
    assign credit_sum    = {1'b0, outst_q} + {1'b0, fifo_cnt_q};
    assign busy          = (state_q == RENDER);
    assign s_axis_tready = (state_q != RENDER);
    assign cfg_wr_en     = (state_q == LOAD) && s_axis_tvalid;
    assign cfg_wr_addr   = cfg_cnt_q;
    assign cfg_wr_data   = s_axis_tdata;
    assign req_valid     = busy && (issue_cnt_q < PW'(NPIX)) && (credit_sum < (OW+1)'(FIFO_DEPTH));
    assign req_x         = x_q;
    assign req_y         = y_q;
    assign req_hs        = req_valid && req_ready;
    assign push          = res_valid && (outst_q != '0);
    assign m_axis_tvalid = (fifo_cnt_q != '0);
    assign m_axis_tdata  = fifo_mem_q[rd_ptr_q];
    assign m_axis_tlast  = m_axis_tvalid && (out_cnt_q == PW'(NPIX - 1));
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign last_hs       = pop && m_axis_tlast;
    assign cfg_err       = cfg_err_q;
    assign frame_done    = frame_done_q;

    always_comb begin
        state_d      = state_q;
        cfg_cnt_d    = cfg_cnt_q;
        x_d          = x_q;
        y_d          = y_q;
        issue_cnt_d  = issue_cnt_q;
        out_cnt_d    = out_cnt_q;
        outst_d      = outst_q;
        fifo_cnt_d   = fifo_cnt_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cfg_err_d    = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            LOAD: begin
                if (s_axis_tvalid) begin
                    if (cfg_cnt_q == CAW'(CFG_WORDS - 1)) begin
                        cfg_cnt_d = '0;
                        if (s_axis_tlast) begin
                            state_d = RENDER;
                        end else begin
                            cfg_err_d = 1'b1;
                            state_d   = SKIP;
                        end
                    end else if (s_axis_tlast) begin
                        cfg_err_d = 1'b1;
                        cfg_cnt_d = '0;
                    end else begin
                        cfg_cnt_d = cfg_cnt_q + CAW'(1);
                    end
                end
            end
            SKIP: begin
                if (s_axis_tvalid && s_axis_tlast) state_d = LOAD;
            end
            RENDER: begin
                if (req_hs) begin
                    issue_cnt_d = issue_cnt_q + PW'(1);
                    if (x_q == XW'(WIDTH - 1)) begin
                        x_d = '0;
                        y_d = y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            default: state_d = LOAD;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + AW'(1);
            out_cnt_d = out_cnt_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + OW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - OW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        case ({req_hs, push})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01:   outst_d = outst_q - OW'(1);
            default: outst_d = outst_q;
        endcase

        // The final beat leaving closes the frame; a new configuration is required.
        if (last_hs) begin
            frame_done_d = 1'b1;
            state_d      = LOAD;
            cfg_cnt_d    = '0;
            x_d          = '0;
            y_d          = '0;
            issue_cnt_d  = '0;
            out_cnt_d    = '0;
            outst_d      = '0;
            fifo_cnt_d   = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= LOAD;
            cfg_cnt_q    <= '0;
            x_q          <= '0;
            y_q          <= '0;
            issue_cnt_q  <= '0;
            out_cnt_q    <= '0;
            outst_q      <= '0;
            fifo_cnt_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cfg_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cfg_cnt_q    <= cfg_cnt_d;
            x_q          <= x_d;
            y_q          <= y_d;
            issue_cnt_q  <= issue_cnt_d;
            out_cnt_q    <= out_cnt_d;
            outst_q      <= outst_d;
            fifo_cnt_q   <= fifo_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cfg_err_q    <= cfg_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge aclk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= res_data;
    end
endmodule

// File: tb/tb_rt_frame_scheduler.sv
// Directed bench for rt_frame_scheduler: table of config bursts with expected outcomes,
// a latency-3 renderer stub, and a hand-written mid-frame reset sequence.
module tb_rt_frame_scheduler;
    localparam int CFG_WORDS  = 27;
    localparam int WIDTH      = 32;
    localparam int HEIGHT     = 32;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int NPIX       = WIDTH * HEIGHT;

    logic              aclk = 1'b0;
    logic              areset = 1'b1;
    logic              s_axis_tready;
    logic [DATA_W-1:0] s_axis_tdata = '0;
    logic              s_axis_tlast = 1'b0;
    logic              s_axis_tvalid = 1'b0;
    logic              cfg_wr_en;
    logic [4:0]        cfg_wr_addr;
    logic [DATA_W-1:0] cfg_wr_data;
    logic              req_valid;
    logic              req_ready = 1'b1;
    logic [4:0]        req_x;
    logic [4:0]        req_y;
    logic              res_valid = 1'b0;
    logic [DATA_W-1:0] res_data = '0;
    logic              m_axis_tvalid;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tlast;
    logic              m_axis_tready = 1'b1;
    logic              busy;
    logic              cfg_err;
    logic              frame_done;

    always #5 aclk = ~aclk;

    rt_frame_scheduler #(
        .CFG_WORDS(CFG_WORDS), .WIDTH(WIDTH), .HEIGHT(HEIGHT),
        .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
        .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
        .res_valid(res_valid), .res_data(res_data),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .busy(busy), .cfg_err(cfg_err), .frame_done(frame_done)
    );

    typedef struct {
        int n_words;
        int tlast_at;
        int exp_writes;
        int exp_errs;
        bit exp_render;
        bit rand_rdy;
        bit stall;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    bit          pipe_v [3];
    logic [31:0] pipe_d [3];
    int exp_rx, exp_ry, issued, popped, out_idx, fd_cnt, err_cnt, wr_cnt, stall_left;
    bit stall_armed, rand_ready, cfg_mode, exp_cfg_en, prev_m_stall;
    int exp_cfg_addr;
    logic [31:0] prev_tdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pix(input int x, input int y);
        return 32'hC0DE_0000 | (32'(y) << 8) | 32'(x);
    endfunction

    task automatic clear_models();
        for (int i = 0; i < 3; i++) begin
            pipe_v[i] = 1'b0;
            pipe_d[i] = '0;
        end
        exp_rx = 0; exp_ry = 0; issued = 0; popped = 0; out_idx = 0; fd_cnt = 0;
        stall_left = 0; prev_m_stall = 1'b0; prev_tdata = '0;
    endtask

    // One clock cycle: entered and left at a falling edge.
    task automatic step();
        bit req_hs;
        int hx, hy;
        res_valid     = pipe_v[2];
        res_data      = pipe_d[2];
        m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (stall_armed && req_valid && exp_rx == 5 && exp_ry == 2) begin
            stall_left  = 20;
            stall_armed = 1'b0;
        end
        req_ready = (stall_left == 0);
        #1;
        if (cfg_mode) begin
            check("cfg_tready", s_axis_tready, 1);
            check("cfg_wr_en", cfg_wr_en, exp_cfg_en);
            if (exp_cfg_en) begin
                check("cfg_wr_addr", cfg_wr_addr, exp_cfg_addr);
                check("cfg_wr_data", cfg_wr_data, s_axis_tdata);
            end
        end
        if (cfg_wr_en) wr_cnt++;
        if (stall_left > 0) begin
            check("stall_req_valid", req_valid, 1);
            stall_left--;
        end
        req_hs = req_valid && req_ready;
        hx = int'(req_x);
        hy = int'(req_y);
        if (req_valid) begin
            check("req_x", req_x, exp_rx);
            check("req_y", req_y, exp_ry);
        end
        if (req_hs) begin
            issued++;
            if (exp_rx == WIDTH - 1) begin
                exp_rx = 0;
                exp_ry++;
            end else begin
                exp_rx++;
            end
            check("credit_limit", (issued - popped) <= FIFO_DEPTH, 1);
        end
        if (m_axis_tvalid) begin
            if (prev_m_stall) check("tdata_hold", m_axis_tdata, prev_tdata);
            if (m_axis_tready) begin
                check("pix_data", m_axis_tdata, pix(out_idx % WIDTH, out_idx / WIDTH));
                check("pix_tlast", m_axis_tlast, out_idx == NPIX - 1);
                out_idx++;
                popped++;
            end
        end
        if (frame_done) fd_cnt++;
        if (cfg_err) err_cnt++;
        prev_m_stall = m_axis_tvalid && !m_axis_tready;
        prev_tdata   = m_axis_tdata;
        @(posedge aclk);
        pipe_v[2] = pipe_v[1]; pipe_d[2] = pipe_d[1];
        pipe_v[1] = pipe_v[0]; pipe_d[1] = pipe_d[0];
        pipe_v[0] = req_hs;    pipe_d[0] = pix(hx, hy);
        @(negedge aclk);
    endtask

    task automatic send_cfg(input int n, input int tlast_at, input int seed);
        cfg_mode = 1'b1;
        for (int i = 0; i < n; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 32'h5A00_0000 + 32'(seed * 256 + i);
            s_axis_tlast  = (i == tlast_at);
            exp_cfg_en    = (i < CFG_WORDS);
            exp_cfg_addr  = i;
            step();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        cfg_mode      = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_s_tready"}, s_axis_tready, 1);
        check({tag, "_req_valid"}, req_valid, 0);
        check({tag, "_m_tvalid"}, m_axis_tvalid, 0);
        check({tag, "_m_tlast"}, m_axis_tlast, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cfg_wr_en"}, cfg_wr_en, 0);
        check({tag, "_cfg_err"}, cfg_err, 0);
        check({tag, "_frame_done"}, frame_done, 0);
    endtask

    task automatic run_frame(input bit rr, input bit do_stall, input int reset_after);
        int cyc = 0;
        clear_models();
        rand_ready  = rr;
        stall_armed = do_stall;
        check("first_req_valid", req_valid, 1);
        check("first_req_x", req_x, 0);
        check("first_req_y", req_y, 0);
        check("render_tready", s_axis_tready, 0);
        while (fd_cnt == 0 && cyc < 6000) begin
            if (reset_after >= 0 && out_idx == reset_after) begin
                areset = 1'b1;
                #1;
                check_idle_outputs("midreset");
                $display("frame reset after %0d pixels", out_idx);
                clear_models();
                @(posedge aclk);
                @(negedge aclk);
                areset = 1'b0;
                #1;
                check_idle_outputs("post_reset");
                @(negedge aclk);
                return;
            end
            step();
            cyc++;
        end
        check("frame_done_seen", fd_cnt, 1);
        repeat (3) step();
        check("frame_done_single", fd_cnt, 1);
        check("pixels_out", out_idx, NPIX);
        check("pixels_issued", issued, NPIX);
        check("end_busy", busy, 0);
        check("end_tready", s_axis_tready, 1);
        check("end_req_valid", req_valid, 0);
        $display("frame rand_ready=%0d stall=%0d pixels=%0d cycles=%0d", rr, do_stall, out_idx, cyc);
        rand_ready = 1'b0;
    endtask

    initial begin
        vec_t vecs [7];
        vecs[0] = '{27, 26, 27, 0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{11, 10, 11, 1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{27, 26, 27, 0, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{30, 29, 27, 1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{27, 26, 27, 0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{ 1,  0,  1, 1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{27, 26, 27, 0, 1'b1, 1'b1, 1'b1};

        clear_models();
        rand_ready = 1'b0; stall_armed = 1'b0; cfg_mode = 1'b0;
        exp_cfg_en = 1'b0; exp_cfg_addr = 0; err_cnt = 0; wr_cnt = 0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        #1;
        check_idle_outputs("reset");
        @(negedge aclk);

        for (int v = 0; v < 7; v++) begin
            err_cnt = 0;
            wr_cnt  = 0;
            send_cfg(vecs[v].n_words, vecs[v].tlast_at, v);
            check("render_entry", busy, vecs[v].exp_render);
            if (vecs[v].exp_render) begin
                run_frame(vecs[v].rand_rdy, vecs[v].stall, -1);
            end else begin
                repeat (3) step();
                check("err_no_req", req_valid, 0);
                check("err_not_busy", busy, 0);
            end
            check("cfg_writes", wr_cnt, vecs[v].exp_writes);
            check("cfg_err_pulses", err_cnt, vecs[v].exp_errs);
            $display("burst %0d: words=%0d tlast_at=%0d writes=%0d errs=%0d render=%0d",
                     v, vecs[v].n_words, vecs[v].tlast_at, wr_cnt, err_cnt, vecs[v].exp_render);
        end

        // Reset in the middle of a frame, then a full fresh frame.
        send_cfg(CFG_WORDS, CFG_WORDS - 1, 9);
        run_frame(1'b0, 1'b0, 500);
        wr_cnt = 0;
        send_cfg(CFG_WORDS, CFG_WORDS - 1, 10);
        check("restart_writes", wr_cnt, CFG_WORDS);
        check("restart_busy", busy, 1);
        run_frame(1'b0, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rt_frame_scheduler.md
Name: rt_frame_scheduler

Overview:
Controller that sequences one frame of the ray-tracing coprocessor. It accepts the scene/camera configuration burst on the AXI-Stream slave, writes it into the renderer's configuration register file, then issues per-pixel render requests in raster order to the renderer core. Results are buffered in a small FIFO and streamed out on the AXI-Stream master with TLAST on the final pixel. Sits between the coprocessor's AXIS ports and the renderer core.

Parameters:
CFG_WORDS, 27, configuration words per frame
WIDTH, 32, frame width in pixels
HEIGHT, 32, frame height in pixels
DATA_W, 32, stream/pixel word width
FIFO_DEPTH, 4, result FIFO depth and maximum in-flight requests (power of two, >=2)

Ports:
aclk  in  1  clock, all logic on rising edge
areset  in  1  asynchronous, active-high reset
s_axis_tready  out  1  ready for config word
s_axis_tdata  in  DATA_W  config word
s_axis_tlast  in  1  last config word
s_axis_tvalid  in  1  config word valid
cfg_wr_en  out  1  config register write strobe
cfg_wr_addr  out  $clog2(CFG_WORDS)  config word index
cfg_wr_data  out  DATA_W  config word
req_valid  out  1  pixel request valid
req_ready  in  1  renderer accepts request
req_x  out  $clog2(WIDTH)  pixel column
req_y  out  $clog2(HEIGHT)  pixel row
res_valid  in  1  renderer result valid (in request order, no backpressure)
res_data  in  DATA_W  pixel result
m_axis_tvalid  out  1  pixel out valid
m_axis_tdata  out  DATA_W  pixel out
m_axis_tlast  out  1  last pixel of frame
m_axis_tready  in  1  downstream ready
busy  out  1  high in RENDER
cfg_err  out  1  one-cycle pulse on config framing error
frame_done  out  1  one-cycle pulse when last pixel handshakes

Behaviour:
- Reset (async assert, sync-released use): state=LOAD, counters/FIFO cleared; s_axis_tready=1 after reset release; all other outputs 0.
- States: LOAD, SKIP, RENDER.
- LOAD: s_axis_tready=1. Each handshake writes cfg_wr_en=1, cfg_wr_addr=word count, cfg_wr_data=tdata same cycle (combinational from beat), count++.
  - Beat with count==CFG_WORDS-1 and tlast=1 -> RENDER next cycle, count=0.
  - tlast=1 with count<CFG_WORDS-1 -> cfg_err pulse next cycle, count=0, stay LOAD.
  - count==CFG_WORDS-1 and tlast=0 -> cfg_err pulse, count=0, go SKIP.
- SKIP: s_axis_tready=1, beats swallowed (no cfg_wr_en) until a tlast beat -> LOAD.
- RENDER: s_axis_tready=0, busy=1. req_valid=1 while pixels remain to issue and (outstanding + fifo_count) < FIFO_DEPTH. req_x/req_y held stable while req_valid && !req_ready. On handshake x++; x wraps WIDTH-1 -> 0 with y++. First request (0,0) asserted the cycle after the final config beat.
- Outstanding counter: +1 on request handshake, -1 on res_valid; simultaneous -> unchanged. res_valid pushes res_data into FIFO; credit rule guarantees space. res_valid with outstanding==0 is ignored (no push).
- Output: m_axis_tvalid = FIFO non-empty; tdata = FIFO head; pop on tvalid&&tready. Simultaneous push/pop on full or empty FIFO legal. Output pixel counter; m_axis_tlast=1 only when counter==WIDTH*HEIGHT-1 and tvalid.
- Last output handshake: frame_done pulse next cycle, state -> LOAD, all counters 0. Next frame requires full config reload.
- tvalid/tdata held stable while !tready (AXIS rule).
- Counter widths: pixel counters $clog2(WIDTH*HEIGHT+1); outstanding $clog2(FIFO_DEPTH+1).
- Reset mid-operation: everything returns to reset values immediately; renderer shares reset so no stale results.

Test Plan:
- 27 config words (tlast on 27th), stub renderer latency 3, m_axis_tready=1 -> cfg_wr_addr 0..26 in order, 1024 output beats in raster order, tlast only on beat 1023, frame_done once, state back to LOAD.
- Same frame with m_axis_tready random 50% -> no lost/duplicated pixels, outstanding+fifo_count never >4, tdata stable while stalled.
- tlast on config word 10 -> cfg_err single pulse, no req_valid; following valid 27-word burst renders full frame.
- 27th config word without tlast, then 3 extra words with tlast on 3rd -> cfg_err pulse, extra words produce no cfg_wr_en, next burst loads normally.
- req_ready low for 20 cycles at pixel (5,2) -> req_x=5, req_y=2 held, no duplicate request after release.
- areset asserted after 500 output pixels -> all outputs to reset values same cycle; fresh config restarts at (0,0) with 1024 pixels.
